mul_sequencer_64: RTL and testbench

- Iterative 64×64 integer multiplier for the pipelined CPU's MUL path.
- Time-shares a single `Adder_64` ripple adder over up to 64 shift-and-add iterations and returns the low 64 bits of the product.
- Sits beside the execute stage; the hazard/stall logic holds the pipeline while `busy` is high.
- One add per cycle keeps the 64-bit ripple carry chain as the only long combinational path.

---
 rtl/mul_seq_pkg.sv | 14 +
 rtl/Adder_64.sv | 26 ++
 rtl/mul_sequencer_64.sv | 92 +++++++++
 tb/tb_mul_sequencer_64.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared constants and types for the iterative 64x64 multiplier.
//   MUL_W       - operand / product width
//   CNT_W       - iteration counter width (counts 0..63)
//   mul_state_t - sequencer control states
package mul_seq_pkg;
  localparam int MUL_W = 64;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;
endpackage

// File: rtl/Adder_64.sv
// 64-bit ripple-carry adder, the only long combinational path of the
// multiplier.
//   a, b : addends
//   sum  : a + b modulo 2^64
//   cout : carry out of bit 63
module Adder_64
  import mul_seq_pkg::*;
(
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  output logic [MUL_W-1:0] sum,
  output logic             cout
);
  logic carry;

  // Bit-serial carry walk; the loop unrolls into a 64-stage ripple chain.
  always_comb begin
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < MUL_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end
endmodule

// File: rtl/mul_sequencer_64.sv
// Iterative shift-and-add 64x64 multiplier returning the low 64 bits of a*b.
// One Adder_64 is reused once per cycle; the pipeline stalls on busy.
//   clk, reset : clock, synchronous active-high reset
//   start      : request (sampled only when not busy)
//   a, b       : multiplicand / multiplier, captured on accepted start
//   busy       : high while iterating
//   done       : one-cycle pulse, product newly valid
//   product    : low 64 bits of a*b, held until the next completion
module mul_sequencer_64
  import mul_seq_pkg::*;
#(
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [MUL_W-1:0] product
);
  mul_state_t       state;
  logic [MUL_W-1:0] mcand;
  logic [MUL_W-1:0] mplier;
  logic [MUL_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [MUL_W-1:0] sum;
  logic [MUL_W-1:0] acc_next;
  logic             unused_cout;  // product is modulo 2^64, carry discarded
  logic             last;

  Adder_64 u_add (
    .a   (acc),
    .b   (mcand),
    .sum (sum),
    .cout(unused_cout)
  );

  assign acc_next = mplier[0] ? sum : acc;

  // Final iteration: counter exhausted, or (early exit) no set bits remain
  // above the one being consumed this cycle.
  assign last = (cnt == CNT_W'(MUL_W - 1)) ||
                ((EARLY_EXIT != 0) && (mplier[MUL_W-1:1] == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
            busy   <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= {mcand[MUL_W-2:0], 1'b0};
          mplier <= {1'b0, mplier[MUL_W-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            product <= acc_next;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_sequencer_64.sv
// Self-checking bench: two DUTs (EARLY_EXIT=1 and 0) share stimulus; a
// cycle-level model built from product = a*b and latency n is compared
// against both every cycle, plus directed literal checks.
module tb_mul_sequencer_64;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        busy1, done1, busy0, done0;
  logic [63:0] prod1, prod0;
  int          pass_cnt = 0;
  int          chk_cnt = 0;

  always #5 clk = ~clk;

  mul_sequencer_64 #(.EARLY_EXIT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .product(prod1)
  );
  mul_sequencer_64 #(.EARLY_EXIT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .product(prod0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int lat(input logic [63:0] bb, input bit ee);
    if (!ee) return 64;
    for (int i = 63; i >= 0; i--) if (bb[i]) return i + 1;
    return 1;
  endfunction

  // Model, index = EARLY_EXIT value: cycles of busy left, done pulse, product.
  int          left  [2];
  bit          mdone [2];
  logic [63:0] mprod [2];
  logic [63:0] pend  [2];
  bit          mvalid = 1'b0;

  always @(posedge clk) begin
    for (int e = 0; e < 2; e++) begin
      if (reset) begin
        left[e]  <= 0;
        mdone[e] <= 1'b0;
        mprod[e] <= '0;
      end else if (left[e] > 0) begin
        left[e]  <= left[e] - 1;
        mdone[e] <= (left[e] == 1);
        if (left[e] == 1) mprod[e] <= pend[e];
      end else begin
        mdone[e] <= 1'b0;
        if (start) begin
          left[e] <= lat(b, e == 1);
          pend[e] <= a * b;
        end
      end
    end
    mvalid <= 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("busy_ee1", {63'd0, busy1}, {63'd0, left[1] > 0});
      check("done_ee1", {63'd0, done1}, {63'd0, mdone[1]});
      check("prod_ee1", prod1, mprod[1]);
      check("busy_ee0", {63'd0, busy0}, {63'd0, left[0] > 0});
      check("done_ee0", {63'd0, done0}, {63'd0, mdone[0]});
      check("prod_ee0", prod0, mprod[0]);
    end
  end

  function automatic logic dn(input int sel);
    return sel == 1 ? done1 : done0;
  endfunction
  function automatic logic bz(input int sel);
    return sel == 1 ? busy1 : busy0;
  endfunction
  function automatic logic [63:0] pr(input int sel);
    return sel == 1 ? prod1 : prod0;
  endfunction

  task automatic wait_idle();
    int k = 0;
    while ((busy1 || busy0 || done1 || done0) && k < 300) begin
      @(negedge clk); k++;
    end
    check("idle_timeout", 64'(k < 300), 64'd1);
  endtask

  // Start one op and check edge of done (edge 1 = start edge), product, busy length.
  task automatic op(input int sel, input logic [63:0] aa, input logic [63:0] bb,
                    input int exp_edge, input logic [63:0] exp_prod, input int exp_busy);
    int edges, busy_cy;
    wait_idle();
    a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0; edges = 1; busy_cy = 0;
    while (!dn(sel) && edges < 200) begin
      if (bz(sel)) busy_cy++;
      @(negedge clk); edges++;
    end
    check("op_done_edge", 64'(edges), 64'(exp_edge));
    check("op_product", pr(sel), exp_prod);
    check("op_busy_cycles", 64'(busy_cy), 64'(exp_busy));
  endtask

  initial begin
    int k;
    @(negedge clk); @(negedge clk);
    check("rst_busy", {63'd0, busy1}, 64'd0);
    check("rst_done", {63'd0, done1}, 64'd0);
    check("rst_prod", prod1, 64'd0);
    reset = 1'b0;

    op(1, 64'd3, 64'd5, 4, 64'd15, 3);
    op(1, 64'h1234, 64'd0, 2, 64'd0, 1);
    op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64'd1, 64);
    op(0, 64'd7, 64'd1, 65, 64'd7, 64);
    op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64'd1, 64);

    // Ignored mid-busy start, then back-to-back start in the DONE cycle.
    wait_idle();
    a = 64'd2; b = 64'd3; start = 1'b1;
    @(negedge clk);                       // after edge 1
    a = 64'd9; b = 64'd9;                 // start still high: must be ignored
    @(negedge clk);                       // after edge 2
    start = 1'b0;
    @(negedge clk);                       // after edge 3: DONE
    check("b2b_done1", {63'd0, done1}, 64'd1);
    check("b2b_prod1", prod1, 64'd6);
    a = 64'd4; b = 64'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_gap", {63'd0, busy1}, 64'd1);
    k = 0;
    while (!done1 && k < 100) begin @(negedge clk); k++; end
    check("b2b_prod2", prod1, 64'd16);

    // Reset in the middle of an operation.
    wait_idle();
    a = 64'd6; b = 64'h80; start = 1'b1;
    @(negedge clk); start = 1'b0;         // after edge 1
    @(negedge clk);                       // after edge 2
    @(negedge clk);                       // after edge 3
    reset = 1'b1;
    @(negedge clk);                       // after edge 4
    check("rmid_busy", {63'd0, busy1}, 64'd0);
    check("rmid_done", {63'd0, done1}, 64'd0);
    check("rmid_prod", prod1, 64'd0);
    check("rmid_busy0", {63'd0, busy0}, 64'd0);
    reset = 1'b0;
    op(1, 64'd6, 64'd7, 4, 64'd42, 3);

    // Random traffic: random starts (including during busy), sparse resets.
    wait_idle();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 64);
      reset = ($urandom_range(0, 400) == 0);
      @(negedge clk);
    end
    start = 1'b0; reset = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
